// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bck/lrck/din in the clk domain and delivers
// complete stereo frames, flagging slots that close short.
module i2s_rx #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  bck,
  input  logic                  lrck,
  input  logic                  din,
  output logic [DATA_WIDTH-1:0] left,
  output logic [DATA_WIDTH-1:0] right,
  output logic                  valid,
  output logic                  err,
  output logic                  locked
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W:0] DW_C = (CNT_W+1)'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]            bck_sync, lrck_sync, din_sync;
  logic                  bck_d;
  logic                  lrck_prev;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg, left_hold, right_hold;
  logic                  left_ok;

  logic                  bck_rise_c, boundary_c, room_c, slot_ok_c;
  logic [CNT_W:0]        count_c;
  logic [DATA_WIDTH-1:0] sh_next_c, slot_val_c;

  // Bit-clock edge detect and slot bookkeeping
  always_comb begin
    bck_rise_c = bck_sync[1] & ~bck_d;
    boundary_c = bck_rise_c & (lrck_sync[1] != lrck_prev);
    room_c     = {1'b0, bit_cnt} < DW_C;
    sh_next_c  = {shreg[DATA_WIDTH-2:0], din_sync[1]};
    slot_val_c = room_c ? sh_next_c : shreg;
    count_c    = {1'b0, bit_cnt} + (CNT_W+1)'(1);
    slot_ok_c  = count_c >= DW_C;
  end

  // Input synchronizers
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      din_sync  <= '0;
      bck_d     <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[0], bck};
      lrck_sync <= {lrck_sync[0], lrck};
      din_sync  <= {din_sync[0], din};
      bck_d     <= bck_sync[1];
    end
  end

  // Slot capture, frame assembly and output registers
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      lrck_prev  <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      left_ok    <= 1'b0;
      locked     <= 1'b0;
      left       <= '0;
      right      <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (bck_rise_c) begin
        lrck_prev <= lrck_sync[1];
        if (boundary_c) begin
          bit_cnt <= '0;
          shreg   <= '0;
          locked  <= 1'b1;
          if (locked) begin
            if (!slot_ok_c) begin
              err     <= 1'b1;
              left_ok <= 1'b0;
            end else if (!lrck_prev) begin
              left_hold <= slot_val_c;
              left_ok   <= 1'b1;
            end else begin
              // A right slot completes the frame only if its left partner was good
              right_hold <= slot_val_c;
              left_ok    <= 1'b0;
              if (left_ok) begin
                left  <= left_hold;
                right <= slot_val_c;
                valid <= 1'b1;
              end
            end
          end
        end else begin
          if (room_c) shreg <= sh_next_c;
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives one I2S stream into a 16-bit and a 24-bit receiver
// and checks both against a slot-level model of the protocol.
module tb_i2s_rx;

  localparam int H = 4;

  logic clk = 1'b0, arst = 1'b0, bck = 1'b0, lrck = 1'b0, din = 1'b0;
  logic [15:0] left16, right16;
  logic [23:0] left24, right24;
  logic valid16, err16, locked16, valid24, err24, locked24;

  always #5 clk = ~clk;

  i2s_rx #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .arst(arst), .bck(bck), .lrck(lrck), .din(din),
    .left(left16), .right(right16), .valid(valid16), .err(err16), .locked(locked16));

  i2s_rx #(.DATA_WIDTH(24)) dut24 (
    .clk(clk), .arst(arst), .bck(bck), .lrck(lrck), .din(din),
    .left(left24), .right(right24), .valid(valid24), .err(err24), .locked(locked24));

  int n_tests = 0, n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Slot-level model: bits of the open slot are recorded by position
  int          dw[2] = '{16, 24};
  bit          m_prev[2], m_locked[2], m_lok[2];
  int          m_cnt[2];
  logic [63:0] m_bits[2];
  logic [31:0] m_lh[2];
  logic [64:0] q16[$], q24[$];

  task automatic push_ev(int k, logic [64:0] ev);
    if (k == 0) q16.push_back(ev);
    else        q24.push_back(ev);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = 0; m_locked[k] = 0; m_lok[k] = 0; m_cnt[k] = 0; m_bits[k] = '0;
    end
    q16.delete(); q24.delete();
  endtask

  task automatic model_rise(int k, bit lr, bit d);
    logic [31:0] v;
    if (m_cnt[k] < 64) m_bits[k][m_cnt[k]] = d;
    m_cnt[k]++;
    if (lr != m_prev[k]) begin
      if (m_locked[k]) begin
        if (m_cnt[k] >= dw[k]) begin
          v = '0;
          for (int i = 0; i < dw[k]; i++) v = {v[30:0], m_bits[k][i]};
          if (!m_prev[k]) begin
            m_lh[k] = v; m_lok[k] = 1;
          end else begin
            if (m_lok[k]) push_ev(k, {1'b0, m_lh[k], v});
            m_lok[k] = 0;
          end
        end else begin
          push_ev(k, {1'b1, 64'd0});
          m_lok[k] = 0;
        end
      end
      m_locked[k] = 1; m_cnt[k] = 0; m_bits[k] = '0;
    end
    m_prev[k] = lr;
  endtask

  // Output monitor, one per receiver
  bit          prev_v[2];
  logic [31:0] last_l[2], last_r[2];
  int          valid_cnt[2], err_cnt[2];

  task automatic cmp(int k, logic v, logic e, logic [31:0] l, logic [31:0] r);
    logic [64:0] ev;
    bit          empty;
    if (v || e) begin
      check($sformatf("valid_err_excl_k%0d", k), 32'(v & e), 32'd0);
      empty = (k == 0) ? (q16.size() == 0) : (q24.size() == 0);
      if (empty) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_pulse_k%0d: valid=%b err=%b, no pulse required", k, v, e);
      end else begin
        if (k == 0) ev = q16.pop_front();
        else        ev = q24.pop_front();
        check($sformatf("pulse_kind_k%0d", k), 32'(e), 32'(ev[64]));
        if (v) begin
          check($sformatf("left_k%0d", k), l, ev[63:32]);
          check($sformatf("right_k%0d", k), r, ev[31:0]);
        end
      end
    end
    if (v) begin
      check($sformatf("valid_width_k%0d", k), 32'(prev_v[k]), 32'd0);
      valid_cnt[k]++;
    end else begin
      check($sformatf("left_hold_k%0d", k), l, last_l[k]);
      check($sformatf("right_hold_k%0d", k), r, last_r[k]);
    end
    if (e) err_cnt[k]++;
    prev_v[k] = v; last_l[k] = l; last_r[k] = r;
  endtask

  always @(negedge clk) begin
    if (arst) begin
      cmp(0, valid16, err16, 32'(left16), 32'(right16));
      cmp(1, valid24, err24, 32'(left24), 32'(right24));
    end else begin
      for (int k = 0; k < 2; k++) begin
        prev_v[k] = 0; last_l[k] = '0; last_r[k] = '0;
      end
    end
  end

  // Stimulus: per-rise lrck and din queues; din lags lrck by one bit
  bit lr_q[$], din_q[$];
  bit lr_credit;

  task automatic bit_cycle(bit lr, bit d);
    bck = 1'b0; lrck = lr; din = d;
    repeat (H) @(negedge clk);
    bck = 1'b1;
    model_rise(0, lr, d);
    model_rise(1, lr, d);
    repeat (H) @(negedge clk);
  endtask

  task automatic add_slot(bit lr, int len, logic [31:0] val);
    int n;
    n = len;
    if (!lr && lr_credit) begin
      n = len - 1; lr_credit = 0;
    end
    for (int i = 0; i < n; i++) lr_q.push_back(lr);
    for (int i = 0; i < len; i++) din_q.push_back(i < 32 ? val[31-i] : 1'($urandom));
  endtask

  task automatic run();
    while (lr_q.size() > 0 && din_q.size() > 0) bit_cycle(lr_q.pop_front(), din_q.pop_front());
    check("pending_k0", q16.size(), 0);
    check("pending_k1", q24.size(), 0);
  endtask

  // Start the next left slot so the open right slot closes
  task automatic close_frame();
    lr_q.push_back(1'b0);
    run();
    lr_credit = 1;
  endtask

  task automatic do_reset();
    bck = 1'b0;
    arst = 1'b0;
    model_reset();
    lr_q.delete(); din_q.delete();
    din_q.push_back(1'($urandom));
    lr_credit = 0;
    repeat (2) @(negedge clk);
    check("rst_left16", 32'(left16), 0);   check("rst_right16", 32'(right16), 0);
    check("rst_left24", 32'(left24), 0);   check("rst_right24", 32'(right24), 0);
    check("rst_valid", {30'd0, valid16, valid24}, 0);
    check("rst_err", {30'd0, err16, err24}, 0);
    check("rst_locked", {30'd0, locked16, locked24}, 0);
    repeat (3) @(negedge clk);
    arst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  int v0, v1, e0, e1;

  task automatic snap();
    v0 = valid_cnt[0]; v1 = valid_cnt[1]; e0 = err_cnt[0]; e1 = err_cnt[1];
  endtask

  task automatic check_counts(string tag, int dv0, int de0, int dv1, int de1);
    check({tag, "_valids16"}, valid_cnt[0] - v0, dv0);
    check({tag, "_errs16"},   err_cnt[0] - e0, de0);
    check({tag, "_valids24"}, valid_cnt[1] - v1, dv1);
    check({tag, "_errs24"},   err_cnt[1] - e1, de1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Case 1: 32-bit slots, lock on first lrck edge, 1234/ABCD
    snap();
    add_slot(0, 12, $urandom);
    run();
    check("locked16_pre", 32'(locked16), 0);
    check("locked24_pre", 32'(locked24), 0);
    add_slot(1, 32, 32'hABCD0000);
    run();
    check("locked16_post", 32'(locked16), 1);
    check("locked24_post", 32'(locked24), 1);
    for (int f = 0; f < 2; f++) begin
      add_slot(0, 32, 32'h12340000);
      add_slot(1, 32, 32'hABCD0000);
    end
    close_frame();
    check("c1_left16", 32'(left16), 32'h1234);
    check("c1_right16", 32'(right16), 32'hABCD);
    check("c1_left24", 32'(left24), 32'h123400);
    check("c1_right24", 32'(right24), 32'hABCD00);
    check_counts("c1", 2, 0, 2, 0);

    // Case 2: 16-bit slots, boundary bit is the LSB
    snap();
    add_slot(0, 16, 32'h80000000);
    add_slot(1, 16, 32'h7FFF0000);
    close_frame();
    check("c2_left16", 32'(left16), 32'h8000);
    check("c2_right16", 32'(right16), 32'h7FFF);
    check_counts("c2", 1, 0, 0, 2);

    // Case 3: truncated left slot
    snap();
    add_slot(0, 10, $urandom);
    add_slot(1, 32, $urandom);
    add_slot(0, 32, 32'h5A5A0000);
    add_slot(1, 32, 32'hC3C30000);
    close_frame();
    check("c3_left16", 32'(left16), 32'h5A5A);
    check("c3_right16", 32'(right16), 32'hC3C3);
    check_counts("c3", 1, 1, 1, 1);

    // Case 4: reset mid right slot, then a partial frame
    add_slot(0, 32, $urandom);
    add_slot(1, 12, $urandom);
    run();
    do_reset();
    snap();
    add_slot(0, 10, $urandom);
    add_slot(1, 32, $urandom);
    add_slot(0, 32, 32'h0F0F0000);
    add_slot(1, 32, 32'hF0F00000);
    close_frame();
    check("c4_left16", 32'(left16), 32'h0F0F);
    check_counts("c4", 1, 0, 1, 0);

    // Case 5: 24-bit capture of a 32-bit slot
    add_slot(0, 32, 32'hFEDCBA00);
    add_slot(1, 32, 32'h13579B00);
    close_frame();
    check("c5_left24", 32'(left24), 32'hFEDCBA);
    check("c5_right24", 32'(right24), 32'h13579B);
    check("c5_left16", 32'(left16), 32'hFEDC);

    // Random frames with random slot lengths and occasional short slots
    for (int f = 0; f < 30; f++) begin
      for (int s = 0; s < 2; s++) begin
        add_slot(1'(s), ($urandom % 8 == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(16, 40)), $urandom);
      end
    end
    close_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
